// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
//   Wishbone master that feeds a uart_interface slave. After reset it programs
//   the baud divider and resets the UART transmitter once, then for each byte
//   of the latched 32-bit word it loads the TX buffer, kicks the transmitter,
//   polls the done flag and clears it.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i                transmit request, only sampled while idle
//   data_i, nbytes_i       payload and byte count minus one, latched on start
//   busy_o, done_o         busy from acceptance until DONE/ERR left; done pulse
//   error_o                sticky error, cleared by next accepted start
//   adr_o, dat_o, dat_i    Wishbone address / write data / read data
//   we_o, sel_o            Wishbone write enable / byte select
//   cyc_o, stb_o           Wishbone cycle / strobe
//   ack_i, err_i           Wishbone acknowledge / error
module uart_tx_sequencer #(
    parameter logic [31:0] BAUD_DIV    = 32'h4000_0000,
    parameter logic [31:0] CTRL_ADDR   = 32'h3,
    parameter logic [31:0] BAUD_ADDR   = 32'h4,
    parameter logic [31:0] STAT_ADDR   = 32'h5,
    parameter logic [31:0] TXBUF_ADDR  = 32'h7,
    parameter logic [7:0]  TX_RST_CMD  = 8'h68,
    parameter logic [7:0]  TX_GO_CMD   = 8'hE0,
    parameter int unsigned DONE_BIT    = 0,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned POLL_GAP    = 8,
    parameter int unsigned POLL_LIMIT  = 4096,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  nbytes_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic        ack_i,
    input  logic        err_i
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GW = $clog2(POLL_GAP + 1);
    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(POLL_GAP - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_BAUD,
        S_CFG_RST,
        S_LOAD,
        S_KICK,
        S_POLL,
        S_CLR,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q;
    logic          cfg_done_q;
    logic [1:0]    idx_q;
    logic [1:0]    nb_q;
    logic [31:0]   data_q;
    logic [TW-1:0] tmo_q;
    logic [GW-1:0] gap_q;
    logic [PW-1:0] polls_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          cyc_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;

    logic [1:0]    shift;
    logic [7:0]    cur_byte;
    logic [31:0]   req_adr;
    logic [31:0]   req_dat;
    logic          req_we;
    logic [3:0]    req_sel;
    logic          stat_done;
    logic          bus_fail;

    // Masking keeps every read-data bit in use while only DONE_BIT matters.
    assign stat_done = |(dat_i & (32'd1 << DONE_BIT));

    // Byte k of the word: counted down from nbytes when MSB first.
    always_comb begin
        shift = MSB_FIRST ? (nb_q - idx_q) : idx_q;
        case (shift)
            2'd0:    cur_byte = data_q[7:0];
            2'd1:    cur_byte = data_q[15:8];
            2'd2:    cur_byte = data_q[23:16];
            default: cur_byte = data_q[31:24];
        endcase
    end

    // Bus request presented by each bus-owning state.
    always_comb begin
        req_adr = STAT_ADDR;
        req_dat = '0;
        req_we  = 1'b1;
        req_sel = 4'b1111;
        case (state_q)
            S_CFG_BAUD: begin
                req_adr = BAUD_ADDR;
                req_dat = BAUD_DIV;
            end
            S_CFG_RST: begin
                req_adr = CTRL_ADDR;
                req_dat = {24'd0, TX_RST_CMD};
            end
            S_LOAD: begin
                req_adr = TXBUF_ADDR;
                req_dat = {24'd0, cur_byte};
                req_sel = 4'b0001;
            end
            S_KICK: begin
                req_adr = CTRL_ADDR;
                req_dat = {24'd0, TX_GO_CMD};
            end
            S_POLL:  req_we = 1'b0;
            default: ;
        endcase
    end

    // Any condition that ends the transfer in ERR: bus error (wins over ack),
    // ack timeout, or the last permitted status read without the done flag.
    always_comb begin
        bus_fail = 1'b0;
        if (cyc_q) begin
            if (err_i)
                bus_fail = 1'b1;
            else if (ack_i)
                bus_fail = (state_q == S_POLL) && !stat_done && (polls_q == POLL_LAST);
            else
                bus_fail = (tmo_q == TMO_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cfg_done_q <= 1'b0;
            idx_q      <= '0;
            nb_q       <= '0;
            data_q     <= '0;
            tmo_q      <= '0;
            gap_q      <= '0;
            polls_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        data_q  <= data_i;
                        nb_q    <= nbytes_i;
                        idx_q   <= '0;
                        gap_q   <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= cfg_done_q ? S_LOAD : S_CFG_BAUD;
                    end
                end
                S_DONE, S_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    // Bus states: issue when idle, hold until ack/err, drop the
                    // cycle on the response so at least one idle cycle follows.
                    if (bus_fail) begin
                        cyc_q      <= 1'b0;
                        error_q    <= 1'b1;
                        cfg_done_q <= 1'b0;
                        state_q    <= S_ERR;
                    end else if (cyc_q) begin
                        if (ack_i) begin
                            cyc_q <= 1'b0;
                            case (state_q)
                                S_CFG_BAUD: state_q <= S_CFG_RST;
                                S_CFG_RST: begin
                                    cfg_done_q <= 1'b1;
                                    state_q    <= S_LOAD;
                                end
                                S_LOAD: state_q <= S_KICK;
                                S_KICK: begin
                                    polls_q <= '0;
                                    state_q <= S_POLL;
                                end
                                S_POLL: begin
                                    if (stat_done) begin
                                        state_q <= S_CLR;
                                    end else begin
                                        polls_q <= polls_q + 1'b1;
                                        gap_q   <= GAP_LOAD;
                                    end
                                end
                                S_CLR: begin
                                    if (idx_q == nb_q) begin
                                        done_q  <= 1'b1;
                                        state_q <= S_DONE;
                                    end else begin
                                        idx_q   <= idx_q + 2'd1;
                                        state_q <= S_LOAD;
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end else if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end else begin
                        cyc_q <= 1'b1;
                        adr_q <= req_adr;
                        dat_q <= req_dat;
                        we_q  <= req_we;
                        sel_q <= req_sel;
                        tmo_q <= '0;
                    end
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign error_o = error_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;
    assign we_o    = we_q;
    assign sel_o   = sel_q;
    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;

endmodule
